reg_file_mp: RTL and testbench

//  Parametrised multi-port register file; next generation of the single-write 8x16 datapath file.

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_clear_fsm.sv | 80 ++++++++
 rtl/reg_file_mp.sv | 173 +++++++++++++++++
 tb/tb_reg_file_mp.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// ----------------------------------------------------------------------------
// rf_pkg
//   Shared types and default sizing for the multi-port register file.
//   clr_state_t  : states of the clear sequencer (idle / sweeping / done)
//   RF_DATA_W    : default entry width
//   RF_DEPTH     : default number of entries
// ----------------------------------------------------------------------------
package rf_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_SWEEP = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_t;

  localparam int RF_DATA_W = 16;
  localparam int RF_DEPTH  = 8;

endpackage

// File: rtl/rf_clear_fsm.sv
// ----------------------------------------------------------------------------
// rf_clear_fsm
//   Clear sequencer for reg_file_mp. On an accepted request it walks a pointer
//   over every entry, one per cycle, then raises a one-cycle done pulse.
//   Ports:
//     clk       in   clock, all state on posedge
//     rst       in   asynchronous, active-low reset
//     clrReq    in   level request, only looked at in CLR_IDLE
//     clrBusy   out  high while sweeping; the array zeroes mem[sweepPtr]
//     clrDone   out  one-cycle pulse after the last entry was cleared
//     wrGate    out  high when port writes may update the array
//     sweepPtr  out  entry being cleared this cycle
//   All outputs are registered alongside the state.
// ----------------------------------------------------------------------------
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clrReq,
  output logic              clrBusy,
  output logic              clrDone,
  output logic              wrGate,
  output logic [ADDR_W-1:0] sweepPtr
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  clr_state_t state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CLR_IDLE;
      sweepPtr <= '0;
      clrBusy  <= 1'b0;
      clrDone  <= 1'b0;
      wrGate   <= 1'b1;
    end else begin
      case (state)
        CLR_IDLE: begin
          clrDone <= 1'b0;
          if (clrReq) begin
            state    <= CLR_SWEEP;
            sweepPtr <= '0;
            clrBusy  <= 1'b1;
            wrGate   <= 1'b0;
          end
        end
        CLR_SWEEP: begin
          // Explicit wrap keeps the pointer in range for non power-of-two depths.
          if (sweepPtr == LAST_PTR) begin
            state    <= CLR_DONE;
            sweepPtr <= '0;
            clrBusy  <= 1'b0;
            clrDone  <= 1'b1;
            wrGate   <= 1'b1;
          end else begin
            sweepPtr <= sweepPtr + 1'b1;
          end
        end
        CLR_DONE: begin
          // A request still held here is picked up from IDLE on the next cycle.
          state   <= CLR_IDLE;
          clrDone <= 1'b0;
        end
        default: begin
          state    <= CLR_IDLE;
          sweepPtr <= '0;
          clrBusy  <= 1'b0;
          clrDone  <= 1'b0;
          wrGate   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// ----------------------------------------------------------------------------
// reg_file_mp
//   Parametrised multi-port register file with a hardware clear sequencer.
//   NUM_WR write ports (higher index wins on a shared address), NUM_RD
//   combinational read ports, and a sweep that zeroes one entry per cycle.
//   Ports:
//     clk          in   clock
//     rst          in   asynchronous, active-low reset (clears array + status)
//     wr_en        in   per-port write enable
//     wr_addr      in   packed write addresses, port p at [p*ADDR_W +: ADDR_W]
//     wr_data      in   packed write data, port p at [p*DATA_W +: DATA_W]
//     rd_addr      in   packed read addresses
//     rd_data      out  packed read data (combinational)
//     clr_req      in   start a clear sweep (sampled while idle)
//     clr_busy     out  sweep in progress
//     clr_done     out  one-cycle pulse at sweep completion
//     wr_conflict  out  registered: two or more enabled ports hit one address
//     wr_drop      out  registered: an enabled write was discarded by a sweep
//   Build option:
//     RF_BYPASS_EN  when defined, reads forward same-cycle write data
//                   (highest-priority matching port) outside a sweep; when
//                   undefined, reads always return the stored value.
// ----------------------------------------------------------------------------
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     wr_conflict,
  output logic                     wr_drop
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wrGate;
  logic [ADDR_W-1:0] sweepPtr;

  logic [DEPTH-1:0]  entHit;
  logic [DATA_W-1:0] entData [DEPTH];
  logic              conflictNow;

  // Addresses at or beyond DEPTH exist only when DEPTH is not a power of two.
  function automatic logic inRange(input logic [ADDR_W-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  rf_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) uClearFsm (
    .clk      (clk),
    .rst      (rst),
    .clrReq   (clr_req),
    .clrBusy  (clr_busy),
    .clrDone  (clr_done),
    .wrGate   (wrGate),
    .sweepPtr (sweepPtr)
  );

  // Per-entry priority resolve: ports scanned low to high so the last
  // matching (highest-index) port supplies the data.
  for (genvar e = 0; e < DEPTH; e++) begin : gEntry
    logic              hit;
    logic [DATA_W-1:0] data;

    always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(e))) begin
          hit  = 1'b1;
          data = wr_data[p*DATA_W +: DATA_W];
        end
      end
    end

    assign entHit[e]  = hit;
    assign entData[e] = data;
  end

  always_comb begin
    conflictNow = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      for (int q = p + 1; q < NUM_WR; q++) begin
        if (wr_en[p] && wr_en[q] &&
            (wr_addr[p*ADDR_W +: ADDR_W] == wr_addr[q*ADDR_W +: ADDR_W]) &&
            inRange(wr_addr[p*ADDR_W +: ADDR_W])) begin
          conflictNow = 1'b1;
        end
      end
    end
  end

  // ---- array update: sweep clear has the array exclusively while busy ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem[e] <= '0;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (clr_busy) begin
          if (sweepPtr == ADDR_W'(e)) begin
            mem[e] <= '0;
          end
        end else if (wrGate && entHit[e]) begin
          mem[e] <= entData[e];
        end
      end
    end
  end

  // ---- status pulses describe the previous cycle's write activity ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_conflict <= 1'b0;
      wr_drop     <= 1'b0;
    end else begin
      wr_conflict <= wrGate & conflictNow;
      wr_drop     <= (~wrGate) & (|wr_en);
    end
  end

  // Read ports.
  for (genvar r = 0; r < NUM_RD; r++) begin : gRead
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] val;

    assign addr = rd_addr[r*ADDR_W +: ADDR_W];

    always_comb begin
      stored = '0;
      if (inRange(addr)) begin
        stored = mem[addr];
      end
    end

`ifdef RF_BYPASS_EN
    // Forward same-cycle write data; suppressed while sweeping because
    // those writes never land.
    always_comb begin
      val = stored;
      if (wrGate && inRange(addr)) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == addr)) begin
            val = wr_data[p*DATA_W +: DATA_W];
          end
        end
      end
    end
`else
    assign val = stored;
`endif

    assign rd_data[r*DATA_W +: DATA_W] = val;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     clr_req;
  logic                     clr_busy;
  logic                     clr_done;
  logic                     wr_conflict;
  logic                     wr_drop;

  reg_file_mp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .clr_req     (clr_req),
    .clr_busy    (clr_busy),
    .clr_done    (clr_done),
    .wr_conflict (wr_conflict),
    .wr_drop     (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_RD*DATA_W-1:0] rd;
    logic                     busy;
    logic                     done;
    logic                     conf;
    logic                     drop;
  } exp_t;

  exp_t expQ[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Stimulus for the next cycle.
  logic [NUM_WR-1:0] sWrEn;
  logic [ADDR_W-1:0] sWrAddr [NUM_WR];
  logic [DATA_W-1:0] sWrData [NUM_WR];
  logic [ADDR_W-1:0] sRdAddr [NUM_RD];
  logic              sClr;
  logic              sRst;

  // Reference model: array contents plus sweep progress counters.
  logic [DATA_W-1:0] mdl [DEPTH];
  bit                mBusy, mDone, mConf, mDrop;
  int                mIdx;

  function automatic void modelReset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    mBusy = 0; mDone = 0; mConf = 0; mDrop = 0; mIdx = 0;
  endfunction

  function automatic logic [DATA_W-1:0] modelRead(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = mdl[a];
`ifdef RF_BYPASS_EN
    if (!mBusy)
      for (int p = 0; p < NUM_WR; p++)
        if (sWrEn[p] && sWrAddr[p] == a) v = sWrData[p];
`endif
    return v;
  endfunction

  function automatic void modelStep();
    bit conf;
    bit fin;
    conf = 0;
    fin  = 0;
    if (!sRst) begin
      modelReset();
      return;
    end
    for (int p = 0; p < NUM_WR; p++)
      for (int q = p + 1; q < NUM_WR; q++)
        if (sWrEn[p] && sWrEn[q] && sWrAddr[p] == sWrAddr[q]) conf = 1;
    mDrop = mBusy && (sWrEn != '0);
    mConf = !mBusy && conf;
    if (mBusy) begin
      mdl[mIdx] = '0;
      mIdx++;
      if (mIdx == DEPTH) begin
        mBusy = 0;
        fin   = 1;
      end
    end else begin
      for (int p = 0; p < NUM_WR; p++)
        if (sWrEn[p]) mdl[sWrAddr[p]] = sWrData[p];
      if (sClr && !mDone) begin
        mBusy = 1;
        mIdx  = 0;
      end
    end
    mDone = fin;
  endfunction

  // One clock: drive inputs just after the edge, queue the expected view,
  // then advance the model through the coming edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    rst     = sRst;
    clr_req = sClr;
    wr_en   = sWrEn;
    for (int p = 0; p < NUM_WR; p++) begin
      wr_addr[p*ADDR_W +: ADDR_W] = sWrAddr[p];
      wr_data[p*DATA_W +: DATA_W] = sWrData[p];
    end
    for (int r = 0; r < NUM_RD; r++) rd_addr[r*ADDR_W +: ADDR_W] = sRdAddr[r];
    if (!sRst) modelReset();
    for (int r = 0; r < NUM_RD; r++) e.rd[r*DATA_W +: DATA_W] = modelRead(sRdAddr[r]);
    e.busy = mBusy;
    e.done = mDone;
    e.conf = mConf;
    e.drop = mDrop;
    expQ.push_back(e);
    modelStep();
  endtask

  task automatic clearStim();
    sWrEn = '0;
    sClr  = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      sWrAddr[p] = ADDR_W'($urandom_range(0, DEPTH - 1));
      sWrData[p] = DATA_W'($urandom);
    end
    for (int r = 0; r < NUM_RD; r++) sRdAddr[r] = ADDR_W'($urandom_range(0, DEPTH - 1));
  endtask

  task automatic wr(input int p, input int a, input logic [DATA_W-1:0] d);
    sWrEn[p]   = 1'b1;
    sWrAddr[p] = ADDR_W'(a);
    sWrData[p] = d;
  endtask

  task automatic rd(input int a0, input int a1);
    sRdAddr[0] = ADDR_W'(a0);
    sRdAddr[1] = ADDR_W'(a1);
  endtask

  task automatic readAll();
    for (int a = 0; a < DEPTH; a++) begin
      clearStim();
      rd(a, DEPTH - 1 - a);
      tick();
    end
  endtask

  task automatic fill();
    for (int a = 0; a < DEPTH; a++) begin
      clearStim();
      wr(0, a, DATA_W'($urandom) | 16'h0001);
      tick();
    end
  endtask

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s @%0t: got 0x%h, expected 0x%h", name, $time, act, req);
    end
  endtask

  // Monitor: outputs are settled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      vectors++;
      chk("rd0",         rd_data[0 +: DATA_W],      e.rd[0 +: DATA_W]);
      chk("rd1",         rd_data[DATA_W +: DATA_W], e.rd[DATA_W +: DATA_W]);
      chk("clr_busy",    DATA_W'(clr_busy),         DATA_W'(e.busy));
      chk("clr_done",    DATA_W'(clr_done),         DATA_W'(e.done));
      chk("wr_conflict", DATA_W'(wr_conflict),      DATA_W'(e.conf));
      chk("wr_drop",     DATA_W'(wr_drop),          DATA_W'(e.drop));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; clr_req = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    modelReset();
    clearStim();

    // Reset held, then all addresses read back as zero.
    sRst = 1'b0;
    tick(); tick();
    sRst = 1'b1;
    readAll();

    // Single write, then read-back.
    clearStim(); wr(0, 3, 16'h1234); rd(3, 3); tick();
    clearStim(); rd(3, 0); tick();

    // Two ports, two addresses.
    clearStim(); wr(0, 2, 16'hAAAA); wr(1, 5, 16'h5555); tick();
    clearStim(); rd(2, 5); tick();

    // Same-address collision: port 1 wins, conflict pulses one cycle.
    clearStim(); wr(0, 4, 16'h1111); wr(1, 4, 16'h2222); tick();
    clearStim(); rd(4, 4); tick();
    clearStim(); rd(4, 4); tick();

    // Full sweep with a write attempted mid-sweep.
    fill();
    clearStim(); sClr = 1'b1; tick();
    for (int i = 0; i < DEPTH + 3; i++) begin
      clearStim();
      if (i == 2) wr(1, 1, 16'hBEEF);
      tick();
    end
    readAll();

    // Reset dropped in the middle of a sweep.
    fill();
    clearStim(); sClr = 1'b1; tick();
    clearStim(); tick(); tick();
    clearStim(); sRst = 1'b0; tick();
    sRst = 1'b1;
    clearStim(); tick(); tick();
    readAll();

    // Same-cycle write and read of one address.
    clearStim(); wr(0, 6, 16'h1357); tick();
    clearStim(); wr(0, 6, 16'hCAFE); rd(6, 6); tick();
    clearStim(); rd(6, 6); tick();

    // Clear request held high across DONE: back-to-back sweeps.
    for (int i = 0; i < 2 * DEPTH + 6; i++) begin
      clearStim();
      sClr = 1'b1;
      if (($urandom & 1) != 0) wr(0, $urandom_range(0, DEPTH - 1), DATA_W'($urandom));
      tick();
    end

    // Randomised traffic with occasional clear requests.
    for (int i = 0; i < 400; i++) begin
      clearStim();
      for (int p = 0; p < NUM_WR; p++) sWrEn[p] = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) sWrAddr[1] = sWrAddr[0];
      sClr = ($urandom_range(0, 39) == 0);
      tick();
    end

    clearStim();
    tick();
    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
